uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter, the transmit-side counterpart of the fabric's UART receive path to the host.
- Accepts one data word per valid/ready handshake and shifts it out on a single line: start bit, data LSB first, optional parity bit, 1 or 2 stop bits.
- Sits between the host-reply/telemetry logic and the board TX pin; fully synchronous to the system clock.

Parameters:
- CLK_FREQ_HZ, 27000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate. CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division, truncated). An elaboration check requires CLKS_PER_BIT >= 2.
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- tx_data  in  DATA_BITS  word to send; sampled only on handshake.
- tx_valid  in  1  upstream has a word.
- tx_ready  out  1  block can accept a word this cycle.
- tx  out  1  serial line; idle level is high. Registered output.
- tx_busy  out  1  high while a frame is on the line (START through the last STOP cycle).

Behaviour:
- Reset (async, while rst_n = 0):
  - tx = 1, tx_ready = 1, tx_busy = 0.
  - State = IDLE; bit counter and baud counter = 0.
  - Reset mid-frame aborts the frame immediately; the line returns high in the same cycle and no partial-frame recovery is attempted.
- Handshake: a word is accepted on a rising edge where tx_valid && tx_ready. tx_data is latched into the shift register at that edge. Later changes to tx_data have no effect on the frame.
- tx_ready is high in IDLE and in the final clock cycle of the last stop bit. It is low at all other times.
- Latency: tx goes low (start bit) on the first clock after acceptance.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START on back-to-back.
  - IDLE: tx = 1. On handshake -> START.
  - START: tx = 0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx = shift[0] and the register shifts right each bit period. Holds DATA_BITS periods, then -> PARITY if PARITY_EN, else -> STOP.
  - PARITY: tx = XOR of the latched data, XOR PARITY_ODD. Holds CLKS_PER_BIT cycles -> STOP.
  - STOP: tx = 1 for STOP_BITS * CLKS_PER_BIT cycles. At the end -> START if a handshake occurred in the final cycle, else -> IDLE.
- Every bit lasts exactly CLKS_PER_BIT clocks. The baud counter restarts at each bit boundary with no cumulative drift.
- Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT clocks.
- Back-to-back words are sent with no idle gap between frames.
- tx_valid held high with no word pending in IDLE: a new frame starts each time tx_ready is offered.
- tx_valid deasserted without a handshake: no frame is sent and there is no side effect.
- tx_busy = 1 from the first START cycle to the last STOP cycle inclusive. It stays 1 across back-to-back frames.

Test Plan (CLK_FREQ_HZ = 1000, BAUD_RATE = 100, so CLKS_PER_BIT = 10):
- Reset behaviour: hold rst_n = 0 -> tx = 1, tx_ready = 1, tx_busy = 0. Release, no valid -> tx stays 1 for 200 cycles.
- 8N1 single byte: send 0xA5 -> tx levels per 10-cycle bit are 0,1,0,1,0,0,1,0,1,1. tx_busy is high for exactly 100 cycles. The start bit begins 1 cycle after the handshake.
- Even parity: PARITY_EN = 1, send 0xA5 (four ones) -> parity bit = 0, frame length 110 cycles. Odd parity (PARITY_ODD = 1) on 0x01 -> parity bit = 0.
- Back-to-back streaming: tx_valid held high with 0x00 then 0xFF -> second start bit directly follows the first stop bit, no idle cycle. tx_ready pulses exactly in the final stop cycle.
- Data stability and STOP_BITS = 2: change tx_data every cycle after acceptance -> transmitted bits match the latched value. With STOP_BITS = 2 the line is high 20 cycles before the next start.
- Reset mid-frame: assert rst_n = 0 during data bit 3 -> tx = 1 in the same cycle. After release, the next frame on 0x3C is correct with no residue from the aborted frame.

Source files
------------

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Brief    : Serial UART transmitter; start, LSB-first data, optional parity,
//            1 or 2 stop bits, valid/ready input handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int c_clks_per_bit = CLK_FREQ_HZ / BAUD_RATE;
  localparam int c_stop_clks    = STOP_BITS * c_clks_per_bit;
  localparam int c_cnt_w        = $clog2(c_stop_clks);
  localparam int c_bit_w        = $clog2(DATA_BITS);

  localparam logic [c_cnt_w-1:0] c_bit_end  = c_cnt_w'(c_clks_per_bit - 1);
  localparam logic [c_cnt_w-1:0] c_stop_end = c_cnt_w'(c_stop_clks - 1);
  localparam logic [c_cnt_w-1:0] c_stop_pre = c_cnt_w'(c_stop_clks - 2);
  localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_BITS - 1);
  localparam logic               c_odd      = (PARITY_ODD != 0);

  generate
    if (c_clks_per_bit < 2) begin : g_chk_baud
      $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
      $error("uart_tx: DATA_BITS must be within 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_baud_cnt;
  logic [c_bit_w-1:0]    r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_parity;

  logic w_accept;
  logic w_bit_end;

  assign w_accept  = tx_valid && tx_ready;
  assign w_bit_end = (r_baud_cnt == c_bit_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (w_accept) begin
            r_shift    <= tx_data;
            r_parity   <= (^tx_data) ^ c_odd;
            r_baud_cnt <= '0;
            r_state    <= ST_START;
            tx         <= 1'b0;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= ST_DATA;
            tx         <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + c_cnt_w'(1);
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == c_last_bit) begin
              if (PARITY_EN != 0) begin
                r_state <= ST_PARITY;
                tx      <= r_parity;
              end else begin
                r_state <= ST_STOP;
                tx      <= 1'b1;
              end
            end else begin
              // Line takes the next bit while the register advances to it.
              r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
              r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
              tx        <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + c_cnt_w'(1);
          end
        end

        ST_PARITY: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_state    <= ST_STOP;
            tx         <= 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + c_cnt_w'(1);
          end
        end

        ST_STOP: begin
          tx <= 1'b1;
          // Ready is raised one cycle early so it is registered for the final stop cycle.
          if (r_baud_cnt == c_stop_pre) begin
            tx_ready <= 1'b1;
          end
          if (r_baud_cnt == c_stop_end) begin
            r_baud_cnt <= '0;
            if (w_accept) begin
              r_shift  <= tx_data;
              r_parity <= (^tx_data) ^ c_odd;
              r_state  <= ST_START;
              tx       <= 1'b0;
              tx_ready <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              tx_busy <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + c_cnt_w'(1);
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_baud_cnt <= '0;
          tx         <= 1'b1;
          tx_ready   <= 1'b1;
          tx_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx; three instances (8N1, 8E1, 8O2)
//            compared cycle by cycle against a frame-level line model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int c_cpb = 10;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_s  [3];
  logic       valid_s [3];
  logic       ready_s [3];
  logic       tx_s    [3];
  logic       busy_s  [3];

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      uart_tx #(
        .CLK_FREQ_HZ (1000),
        .BAUD_RATE   (100),
        .DATA_BITS   (8),
        .PARITY_EN   ((gi > 0) ? 1 : 0),
        .PARITY_ODD  ((gi == 2) ? 1 : 0),
        .STOP_BITS   ((gi == 2) ? 2 : 1)
      ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (data_s[gi]),
        .tx_valid (valid_s[gi]),
        .tx_ready (ready_s[gi]),
        .tx       (tx_s[gi]),
        .tx_busy  (busy_s[gi])
      );
    end
  endgenerate

  // Line model: instance configuration and the level of each bit slot in a frame.
  function automatic int par_en(int idx);
    return (idx > 0) ? 1 : 0;
  endfunction

  function automatic int stop_bits(int idx);
    return (idx == 2) ? 2 : 1;
  endfunction

  function automatic int frame_len(int idx);
    return (1 + 8 + par_en(idx) + stop_bits(idx)) * c_cpb;
  endfunction

  function automatic logic exp_level(int idx, logic [7:0] d, int b);
    logic odd;
    odd = (idx == 2);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par_en(idx) == 1 && b == 9) return (^d) ^ odd;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, presents a word and returns one cycle after the accepting edge.
  task automatic start_word(int idx, logic [7:0] d, bit hold);
    int w = 0;
    while (ready_s[idx] !== 1'b1 && w < 1000) begin
      tick();
      w++;
    end
    n_checks++;
    if (w >= 1000) $display("FAIL ready_wait: dut%0d ready=%b required 1", idx, ready_s[idx]);
    else n_pass++;
    valid_s[idx] = 1'b1;
    data_s[idx]  = d;
    tick();
    if (!hold) valid_s[idx] = 1'b0;
  endtask

  task automatic check_frame(int idx, logic [7:0] d, bit hold, bit scramble,
                             bit chain, logic [7:0] next_d);
    int len;
    logic el;
    len = frame_len(idx);
    for (int c = 0; c < len; c++) begin
      el = exp_level(idx, d, c / c_cpb);
      n_checks++;
      if (tx_s[idx] !== el)
        $display("FAIL frame_tx: dut%0d data=%h cycle %0d tx=%b required %b", idx, d, c, tx_s[idx], el);
      else n_pass++;
      n_checks++;
      if (busy_s[idx] !== 1'b1)
        $display("FAIL frame_busy: dut%0d cycle %0d busy=%b required 1", idx, c, busy_s[idx]);
      else n_pass++;
      n_checks++;
      if (ready_s[idx] !== (c == len - 1))
        $display("FAIL frame_ready: dut%0d cycle %0d ready=%b required %b", idx, c, ready_s[idx], (c == len - 1));
      else n_pass++;
      if (c == len - 1) begin
        valid_s[idx] = chain;
        if (chain) data_s[idx] = next_d;
      end else if (scramble) begin
        data_s[idx] = 8'($urandom);
        if (!hold) valid_s[idx] = 1'($urandom);
      end
      tick();
    end
    if (!chain) begin
      n_checks++;
      if (tx_s[idx] !== 1'b1 || busy_s[idx] !== 1'b0 || ready_s[idx] !== 1'b1)
        $display("FAIL frame_idle: dut%0d tx/busy/ready=%b%b%b required 101", idx, tx_s[idx], busy_s[idx], ready_s[idx]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_s[i] = 1'b0;
      data_s[i]  = 8'h00;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (tx_s[i] !== 1'b1 || ready_s[i] !== 1'b1 || busy_s[i] !== 1'b0)
        $display("FAIL reset_state: dut%0d tx/ready/busy=%b%b%b required 110", i, tx_s[i], ready_s[i], busy_s[i]);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (tx_s[i] !== 1'b1 || busy_s[i] !== 1'b0)
          $display("FAIL idle_line: dut%0d cycle %0d tx/busy=%b%b required 10", i, c, tx_s[i], busy_s[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_8n1();
    start_word(0, 8'hA5, 1'b0);
    check_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_parity();
    start_word(1, 8'hA5, 1'b0);
    check_frame(1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
    start_word(2, 8'h01, 1'b0);
    check_frame(2, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    start_word(0, 8'h00, 1'b1);
    data_s[0] = 8'hFF;
    check_frame(0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF);
    check_frame(0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
    start_word(2, 8'h5A, 1'b1);
    check_frame(2, 8'h5A, 1'b1, 1'b0, 1'b1, 8'hC3);
    check_frame(2, 8'hC3, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_stability();
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      start_word(i, d, 1'b0);
      check_frame(i, d, 1'b0, 1'b1, 1'b0, 8'h00);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'($urandom) & 8'hF7;
    start_word(0, d, 1'b0);
    repeat (4 * c_cpb + 3) tick();
    n_checks++;
    if (tx_s[0] !== 1'b0)
      $display("FAIL mid_bit3: tx=%b required 0", tx_s[0]);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_s[0] !== 1'b1 || ready_s[0] !== 1'b1 || busy_s[0] !== 1'b0)
      $display("FAIL mid_reset: tx/ready/busy=%b%b%b required 110", tx_s[0], ready_s[0], busy_s[0]);
    else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    start_word(0, 8'h3C, 1'b0);
    check_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    int idx;
    bit ch;
    logic [7:0] d;
    logic [7:0] nd;
    for (int r = 0; r < 6; r++) begin
      idx = $urandom_range(0, 2);
      repeat ($urandom_range(0, 5)) tick();
      d = 8'($urandom);
      start_word(idx, d, 1'b0);
      for (int k = 0; k < 3; k++) begin
        nd = 8'($urandom);
        ch = (k < 2) ? 1'($urandom) : 1'b0;
        check_frame(idx, d, 1'b0, 1'b1, ch, nd);
        if (!ch) break;
        valid_s[idx] = 1'b0;
        d = nd;
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_stability();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
